// File: rtl/array_prod.sv
// array_prod: sequential signed fixed-point dot product, one multiply per clock.
//   clock     - rising-edge clock
//   reset     - async active-low clear; its release starts a new computation
//   arrayA/B  - packed vectors, element i at [i*BITWIDTH +: BITWIDTH], Q(QN).(QM)
//   dataReady - high once result holds the completed dot product
//   result    - saturated Q(QN).(QM) dot product, held until the next reset
module array_prod #(
  parameter int NUM_ELEMS = 8,
  parameter int QN = 6,
  parameter int QM = 11,
  localparam int BITWIDTH = QN + QM + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [BITWIDTH*NUM_ELEMS-1:0] arrayA,
  input  logic [BITWIDTH*NUM_ELEMS-1:0] arrayB,
  output logic                          dataReady,
  output logic [BITWIDTH-1:0]           result
);
  localparam int ACCW = 2 * BITWIDTH + $clog2(NUM_ELEMS);
  localparam int IW = $clog2(NUM_ELEMS + 1);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;
  typedef enum logic {ACCUM, DONE} stateType;
  stateType state, stateNext;
  logic [IW-1:0] index;
  logic signed [BITWIDTH-1:0] elemA, elemB;
  logic signed [2*BITWIDTH-1:0] product;
  logic signed [ACCW-1:0] acc, shifted;
  logic [BITWIDTH-1:0] saturated;
  logic lastElem;
  always_comb begin
    elemA = '0;
    elemB = '0;
    for (int i = 0; i < NUM_ELEMS; i++)
      if (index == IW'(i)) begin
        elemA = arrayA[i*BITWIDTH +: BITWIDTH];
        elemB = arrayB[i*BITWIDTH +: BITWIDTH];
      end
  end
  assign product = elemA * elemB;
  assign shifted = acc >>> QM;
  assign saturated = shifted > MAXV ? MAXV[BITWIDTH-1:0] :
                     shifted < MINV ? MINV[BITWIDTH-1:0] : shifted[BITWIDTH-1:0];
  // index runs one past the last element so the extra edge can load result
  assign lastElem = index == IW'(NUM_ELEMS);
  always_comb begin
    stateNext = state;
    if (state == ACCUM && lastElem) stateNext = DONE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
      index <= '0;
      acc <= '0;
      result <= '0;
      dataReady <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == ACCUM && !lastElem) begin
        acc <= acc + ACCW'(product);
        index <= index + IW'(1);
      end
      if (state == ACCUM && lastElem) begin
        result <= saturated;
        dataReady <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_array_prod.sv
// tb_array_prod: directed self-checking bench for array_prod.
module tb_array_prod;
  localparam int N = 8;
  localparam int W = 18;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [W*N-1:0] arrayA, arrayB;
  logic dataReady;
  logic [W-1:0] result;
  int assertions = 0;
  int failures = 0;

  array_prod #(N, 6, 11) dut (
    .clock(clock), .reset(reset), .arrayA(arrayA), .arrayB(arrayB),
    .dataReady(dataReady), .result(result)
  );

  always #5 clock = ~clock;

  function automatic logic [W*N-1:0] fill(input logic [W-1:0] v);
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic startRun(input logic [W*N-1:0] a, input logic [W*N-1:0] b);
    reset = 1'b0;
    arrayA = a;
    arrayB = b;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    arrayA = fill(18'h00800);
    arrayB = fill(18'h00800);
    reset = 1'b0;
    waitEdges(2);
    assertions++;
    if (dataReady !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", dataReady); end
    assertions++;
    if (result !== 18'h0) begin failures++; $display("FAIL reset_result got %h want 00000", result); end
  endtask

  task automatic test_basic;
    startRun(fill(18'h00800), fill(18'h00400));
    waitEdges(8);
    assertions++;
    if (dataReady !== 1'b0) begin failures++; $display("FAIL basic_early_ready got %b want 0 at edge 8", dataReady); end
    waitEdges(1);
    assertions++;
    if (dataReady !== 1'b1) begin failures++; $display("FAIL basic_ready got %b want 1 at edge 9", dataReady); end
    assertions++;
    if (result !== 18'h02000) begin failures++; $display("FAIL basic_result got %h want 02000", result); end
    waitEdges(5);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h02000) begin
      failures++; $display("FAIL basic_hold got %b/%h want 1/02000", dataReady, result);
    end
  endtask

  task automatic test_negative;
    startRun(fill(18'h3F800), fill(18'h00800));
    waitEdges(8);
    assertions++;
    if (dataReady !== 1'b0) begin failures++; $display("FAIL neg_early_ready got %b want 0", dataReady); end
    waitEdges(1);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h3C000) begin
      failures++; $display("FAIL neg_result got %b/%h want 1/3c000", dataReady, result);
    end
  endtask

  task automatic test_saturation;
    startRun(fill(18'h08000), fill(18'h08000));
    waitEdges(9);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h1FFFF) begin
      failures++; $display("FAIL sat_pos got %b/%h want 1/1ffff", dataReady, result);
    end
    startRun(fill(18'h38000), fill(18'h08000));
    waitEdges(9);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h20000) begin
      failures++; $display("FAIL sat_neg got %b/%h want 1/20000", dataReady, result);
    end
  endtask

  task automatic test_floor;
    logic [W*N-1:0] a, b;
    a = '0;
    b = '0;
    a[W-1:0] = 18'h00001;
    b[W-1:0] = 18'h00001;
    startRun(a, b);
    waitEdges(9);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h00000) begin
      failures++; $display("FAIL floor_pos got %b/%h want 1/00000", dataReady, result);
    end
    a[W-1:0] = 18'h3FFFF;
    startRun(a, b);
    waitEdges(9);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h3FFFF) begin
      failures++; $display("FAIL floor_neg got %b/%h want 1/3ffff", dataReady, result);
    end
  endtask

  // A[i] = i+1, B alternates +1/-1: 1-2+3-4+5-6+7-8 = -4.0
  task automatic test_mixed;
    logic [W*N-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = 18'((i + 1) << 11);
      b[i*W +: W] = (i % 2 == 1) ? 18'h3F800 : 18'h00800;
    end
    startRun(a, b);
    waitEdges(9);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h3E000) begin
      failures++; $display("FAIL mixed got %b/%h want 1/3e000", dataReady, result);
    end
  endtask

  task automatic test_hold;
    startRun(fill(18'h00800), fill(18'h00400));
    waitEdges(9);
    arrayA = fill(18'h08000);
    arrayB = fill(18'h3F800);
    waitEdges(4);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h02000) begin
      failures++; $display("FAIL hold got %b/%h want 1/02000", dataReady, result);
    end
  endtask

  task automatic test_reset_in_done;
    startRun(fill(18'h00800), fill(18'h00800));
    waitEdges(9);
    @(negedge clock);
    reset = 1'b0;
    #1;
    assertions++;
    if (dataReady !== 1'b0 || result !== 18'h0) begin
      failures++; $display("FAIL done_abort got %b/%h want 0/00000", dataReady, result);
    end
  endtask

  task automatic test_abort;
    startRun(fill(18'h08000), fill(18'h08000));
    waitEdges(4);
    reset = 1'b0;
    #1;
    assertions++;
    if (dataReady !== 1'b0 || result !== 18'h0) begin
      failures++; $display("FAIL abort_clear got %b/%h want 0/00000", dataReady, result);
    end
    startRun(fill(18'h01000), fill(18'h00800));
    waitEdges(8);
    assertions++;
    if (dataReady !== 1'b0) begin failures++; $display("FAIL abort_early_ready got %b want 0", dataReady); end
    waitEdges(1);
    assertions++;
    if (dataReady !== 1'b1 || result !== 18'h08000) begin
      failures++; $display("FAIL abort_restart got %b/%h want 1/08000", dataReady, result);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_saturation;
    test_floor;
    test_mixed;
    test_hold;
    test_reset_in_done;
    test_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
